// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns a command/response strobe pair into single write or read transactions.
// Optional AXI_LITE_MASTER_LATENCY_EN adds o_rsp_latency (saturating accept-to-response cycle count).
module axi_lite_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
`ifdef AXI_LITE_MASTER_LATENCY_EN
  , parameter int LAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_write,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp
`ifdef AXI_LITE_MASTER_LATENCY_EN
  , output logic [LAT_WIDTH-1:0] o_rsp_latency
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RESP} state_t;

  state_t                state, state_nxt;
  logic                  cmd_rdy_q;
  logic                  write_q, aw_done, w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [1:0]            resp_q;
  logic                  rsp_write_q;
  logic                  accept, aw_hs, w_hs;

  assign accept = i_cmd_valid & cmd_rdy_q;
  assign aw_hs  = o_awvalid & i_awready;
  assign w_hs   = o_wvalid & i_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_cmd_ready = cmd_rdy_q;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_rsp_valid = 1'b0;
    case (state)
      S_IDLE:    if (accept) state_nxt = i_cmd_write ? S_WR : S_RD_ADDR;
      S_WR: begin
        o_awvalid = ~aw_done;
        o_wvalid  = ~w_done;
        if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        o_bready = 1'b1;
        if (i_bvalid) state_nxt = S_RESP;
      end
      S_RD_ADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        o_rready = 1'b1;
        if (i_rvalid) state_nxt = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // cmd_ready is registered so it reads 0 while rst is held, then rises one cycle after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_rdy_q   <= 1'b0;
      write_q     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      rsp_write_q <= 1'b0;
    end else begin
      cmd_rdy_q <= (state_nxt == S_IDLE);
      if (accept) begin
        write_q <= i_cmd_write;
        addr_q  <= i_cmd_addr;
        wdata_q <= i_cmd_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state == S_WR_RESP && i_bvalid) begin
        resp_q      <= i_bresp;
        rdata_q     <= '0;
        rsp_write_q <= 1'b1;
      end
      if (state == S_RD_DATA && i_rvalid) begin
        resp_q      <= i_rresp;
        rdata_q     <= i_rdata;
        rsp_write_q <= 1'b0;
      end
    end
  end

  assign o_awaddr    = addr_q;
  assign o_araddr    = addr_q;
  assign o_wdata     = wdata_q;
  assign o_rsp_write = rsp_write_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;

`ifdef AXI_LITE_MASTER_LATENCY_EN
  logic [LAT_WIDTH-1:0] lat_q;
  logic                 busy;

  assign busy = (state == S_WR) || (state == S_WR_RESP) ||
                (state == S_RD_ADDR) || (state == S_RD_DATA);

  // accept cycle counts as 0, so the first in-flight cycle already reads 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    lat_q <= '0;
    else if (accept)            lat_q <= LAT_WIDTH'(1);
    else if (busy && ~&lat_q)   lat_q <= lat_q + 1'b1;
  end

  assign o_rsp_latency = lat_q;
`endif

  logic unused_write_q;
  assign unused_write_q = write_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: reactive AXI-Lite slave plus a memory/latency reference model.
module tb_axi_lite_master;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_write;
  logic [DW-1:0] o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic          o_awvalid, i_awready;
  logic [AW-1:0] o_awaddr;
  logic          o_wvalid, i_wready;
  logic [DW-1:0] o_wdata;
  logic          i_bvalid, o_bready;
  logic [1:0]    i_bresp;
  logic          o_arvalid, i_arready;
  logic [AW-1:0] o_araddr;
  logic          i_rvalid, o_rready;
  logic [DW-1:0] i_rdata;
  logic [1:0]    i_rresp;
`ifdef AXI_LITE_MASTER_LATENCY_EN
  localparam int LW = 4;
  logic [LW-1:0] o_rsp_latency;
`endif

  always #5 clk = ~clk;

  axi_lite_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
`ifdef AXI_LITE_MASTER_LATENCY_EN
    , .LAT_WIDTH(LW)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
`ifdef AXI_LITE_MASTER_LATENCY_EN
    , .o_rsp_latency(o_rsp_latency)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference memory: the slave's register contents as seen by completed OKAY writes
  logic [DW-1:0] mem [logic [AW-1:0]];

  int          obs_aw, obs_w, obs_ar, obs_viol, obs_lat;
  bit          obs_timeout;
  logic [34:0] obs_rsp;
  int          obs_latv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    logic r;
    r = |{o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_rdata, o_rsp_resp, o_awvalid, o_awaddr,
          o_wvalid, o_wdata, o_bready, o_arvalid, o_araddr, o_rready};
`ifdef AXI_LITE_MASTER_LATENCY_EN
    r = r | (|o_rsp_latency);
`endif
    return r;
  endfunction

  function automatic int model_lat(bit wr, int aw_d, int w_d, int b_d, int ar_d, int r_d);
    return wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
  endfunction

  function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // issue one command and play the slave with the given per-channel stall counts
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int aw_d, input int w_d, input int b_d, input int ar_d,
                         input int r_d, input logic [1:0] resp, input int stall);
    int n, cyc, awc, wc, bc, arc, rc, sc;
    bit done, seen, p_aw, p_w, p_ar;
    logic [DW-1:0] rd_val;
    obs_aw = 0; obs_w = 0; obs_ar = 0; obs_viol = 0; obs_lat = 0; obs_latv = 0;
    obs_timeout = 1'b0; obs_rsp = '0;
    rd_val = mem_rd(addr);
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_wdata = wd;
    n = 0;
    while (!o_cmd_ready && n < 50) begin step(); n++; end
    if (!o_cmd_ready) begin
      obs_timeout = 1'b1; i_cmd_valid = 1'b0;
      return;
    end
    step();
    i_cmd_valid = 1'b0; i_cmd_addr = AW'($urandom); i_cmd_wdata = $urandom;
    cyc = 1; awc = 0; wc = 0; bc = 0; arc = 0; rc = 0; sc = 0;
    done = 1'b0; seen = 1'b0; p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
    while (!done && cyc < 300) begin
      if (o_cmd_ready) obs_viol++;
      if (o_awvalid && o_awaddr !== addr) obs_viol++;
      if (o_wvalid && o_wdata !== wd) obs_viol++;
      if (o_arvalid && o_araddr !== addr) obs_viol++;
      if (o_bready && (o_awvalid | o_wvalid | o_arvalid | o_rready | o_rsp_valid)) obs_viol++;
      if (o_rready && (o_awvalid | o_wvalid | o_arvalid | o_bready | o_rsp_valid)) obs_viol++;
      if ((p_aw && !o_awvalid) || (p_w && !o_wvalid) || (p_ar && !o_arvalid)) obs_viol++;
      i_awready = o_awvalid && awc >= aw_d;
      if (o_awvalid) begin if (i_awready) obs_aw++; awc++; end
      i_wready = o_wvalid && wc >= w_d;
      if (o_wvalid) begin if (i_wready) obs_w++; wc++; end
      i_arready = o_arvalid && arc >= ar_d;
      if (o_arvalid) begin if (i_arready) obs_ar++; arc++; end
      p_aw = o_awvalid && !i_awready;
      p_w  = o_wvalid && !i_wready;
      p_ar = o_arvalid && !i_arready;
      i_bvalid = o_bready && bc >= b_d;
      i_bresp  = i_bvalid ? resp : 2'b00;
      if (o_bready) bc++;
      i_rvalid = o_rready && rc >= r_d;
      i_rdata  = i_rvalid ? rd_val : $urandom;
      i_rresp  = i_rvalid ? resp : 2'b00;
      if (o_rready) rc++;
      if (o_rsp_valid) begin
        if (!seen) begin
          seen = 1'b1; obs_lat = cyc;
          obs_rsp = {o_rsp_write, o_rsp_rdata, o_rsp_resp};
`ifdef AXI_LITE_MASTER_LATENCY_EN
          obs_latv = int'(o_rsp_latency);
`endif
        end else begin
          if ({o_rsp_write, o_rsp_rdata, o_rsp_resp} !== obs_rsp) obs_viol++;
`ifdef AXI_LITE_MASTER_LATENCY_EN
          if (int'(o_rsp_latency) != obs_latv) obs_viol++;
`endif
        end
        i_rsp_ready = (sc >= stall);
        if (i_rsp_ready) done = 1'b1;
        sc++;
      end else begin
        i_rsp_ready = 1'b0;
      end
      step();
      cyc++;
    end
    {i_awready, i_wready, i_arready, i_bvalid, i_rvalid, i_rsp_ready} = '0;
    i_bresp = 2'b00; i_rresp = 2'b00; i_rdata = '0;
    if (!done) obs_timeout = 1'b1;
    else if (o_rsp_valid || !o_cmd_ready) obs_viol++;
    if (done && wr && resp == 2'b00) mem[addr] = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {i_cmd_valid, i_cmd_write, i_rsp_ready, i_awready, i_wready, i_bvalid, i_arready, i_rvalid} = '0;
    i_cmd_addr = '0; i_cmd_wdata = '0; i_bresp = 2'b00; i_rdata = '0; i_rresp = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (any_out() !== 1'b0) begin errors++; $display("FAIL reset_outputs got nonzero want all 0"); end
    @(negedge clk); rst = 1'b0;
    step();
    checks++;
    if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got %b want 1", o_cmd_ready); end
  endtask

  task automatic test_zero_wait_write();
    run_txn(1'b1, 16'h0000, 32'h0000_0001, 0, 0, 0, 0, 0, 2'b00, 0);
    checks++;
    if (obs_timeout || obs_aw != 1 || obs_w != 1) begin
      errors++; $display("FAIL zw_write_beats got aw=%0d w=%0d to=%0b want 1 1 0", obs_aw, obs_w, obs_timeout);
    end
    checks++;
    if (obs_rsp !== {1'b1, 32'h0, 2'b00}) begin errors++; $display("FAIL zw_write_rsp got %h want %h", obs_rsp, {1'b1, 32'h0, 2'b00}); end
    checks++;
    if (obs_lat != 3 || obs_viol != 0) begin errors++; $display("FAIL zw_write_lat got %0d viol=%0d want 3 0", obs_lat, obs_viol); end
`ifdef AXI_LITE_MASTER_LATENCY_EN
    checks++;
    if (obs_latv != 3) begin errors++; $display("FAIL zw_latency_port got %0d want 3", obs_latv); end
`endif
  endtask

  task automatic test_readback();
    run_txn(1'b0, 16'h0000, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0);
    checks++;
    if (obs_timeout || obs_rsp !== {1'b0, 32'h0000_0001, 2'b00} || obs_ar != 1) begin
      errors++; $display("FAIL readback got %h ar=%0d want %h ar=1", obs_rsp, obs_ar, {1'b0, 32'h1, 2'b00});
    end
  endtask

  task automatic test_skewed_write();
    run_txn(1'b1, 16'h0024, 32'hCAFE_F00D, 4, 0, 0, 0, 0, 2'b00, 0);
    checks++;
    if (obs_timeout || obs_aw != 1 || obs_w != 1 || obs_viol != 0) begin
      errors++; $display("FAIL skew_write got aw=%0d w=%0d viol=%0d want 1 1 0", obs_aw, obs_w, obs_viol);
    end
    checks++;
    if (obs_lat != model_lat(1'b1, 4, 0, 0, 0, 0)) begin
      errors++; $display("FAIL skew_write_lat got %0d want %0d", obs_lat, model_lat(1'b1, 4, 0, 0, 0, 0));
    end
  endtask

  task automatic test_error_backpressure();
    logic [34:0] exp;
    exp = {1'b0, mem_rd(16'h0010), 2'b10};
    run_txn(1'b0, 16'h0010, 32'h0, 0, 0, 0, 0, 0, 2'b10, 5);
    checks++;
    if (obs_timeout || obs_rsp !== exp) begin errors++; $display("FAIL err_rsp got %h want %h", obs_rsp, exp); end
    checks++;
    if (obs_viol != 0) begin errors++; $display("FAIL err_stall_stability got viol=%0d want 0", obs_viol); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit leaked;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 16'h0100; i_cmd_wdata = 32'h1234_5678;
    n = 0;
    while (!o_cmd_ready && n < 20) begin step(); n++; end
    step();
    i_cmd_valid = 1'b0; i_awready = 1'b1; i_wready = 1'b1;
    n = 0;
    while (!o_bready && n < 20) begin step(); n++; end
    i_awready = 1'b0; i_wready = 1'b0;
    checks++;
    if (o_bready !== 1'b1) begin errors++; $display("FAIL rstmid_reach_wr_resp got bready=%b want 1", o_bready); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (any_out() !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got nonzero want all 0"); end
    @(negedge clk); rst = 1'b0;
    leaked = 1'b0;
    repeat (4) begin step(); if (o_rsp_valid) leaked = 1'b1; end
    checks++;
    if (leaked) begin errors++; $display("FAIL rstmid_no_rsp got rsp_valid=1 want 0"); end
    run_txn(1'b0, 16'h0000, 32'h0, 0, 1, 0, 1, 2, 2'b00, 1);
    checks++;
    if (obs_timeout || obs_rsp !== {1'b0, mem_rd(16'h0000), 2'b00} || obs_viol != 0) begin
      errors++; $display("FAIL rstmid_next_cmd got %h viol=%0d want %h 0", obs_rsp, obs_viol, {1'b0, mem_rd(16'h0000), 2'b00});
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [1:0] rs;
      int aw_d, w_d, b_d, ar_d, r_d, st, el;
      logic [34:0] exp;
      wr = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 7) * 4);
      d = $urandom;
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 4);
      ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 4); st = $urandom_range(0, 3);
      exp = wr ? {1'b1, 32'h0, rs} : {1'b0, mem_rd(a), rs};
      el = model_lat(wr, aw_d, w_d, b_d, ar_d, r_d);
      run_txn(wr, a, d, aw_d, w_d, b_d, ar_d, r_d, rs, st);
      checks++;
      if (obs_timeout || obs_rsp !== exp || obs_lat != el || obs_viol != 0 ||
          obs_aw != (wr ? 1 : 0) || obs_w != (wr ? 1 : 0) || obs_ar != (wr ? 0 : 1)) begin
        errors++;
        $display("FAIL random[%0d] got rsp=%h lat=%0d viol=%0d aw/w/ar=%0d/%0d/%0d want rsp=%h lat=%0d",
                 t, obs_rsp, obs_lat, obs_viol, obs_aw, obs_w, obs_ar, exp, el);
      end
`ifdef AXI_LITE_MASTER_LATENCY_EN
      checks++;
      if (obs_latv != ((el > 15) ? 15 : el)) begin
        errors++; $display("FAIL random_latency[%0d] got %0d want %0d", t, obs_latv, (el > 15) ? 15 : el);
      end
`endif
    end
  endtask

`ifdef AXI_LITE_MASTER_LATENCY_EN
  task automatic test_latency_sat();
    run_txn(1'b1, 16'h0008, 32'h5A5A_5A5A, 0, 0, 20, 0, 0, 2'b00, 0);
    checks++;
    if (obs_timeout || obs_latv != 15) begin errors++; $display("FAIL lat_saturate got %0d want 15", obs_latv); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_write();
    test_readback();
    test_skewed_write();
    test_error_backpressure();
    test_reset_mid();
    test_random();
`ifdef AXI_LITE_MASTER_LATENCY_EN
    test_latency_sat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
